// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration with an optional fixed-priority mode. Each op takes
// an accepting edge (IDLE/DONE -> EXEC, gnt pulse) and an EXEC edge
// (EXEC -> DONE, result captured, done pulse). A DONE cycle can accept the
// next request, so ops can issue back to back every two cycles.
//
// Handshake: a requester holds req/a/b/ctrl stable until the edge at which it
// samples gnt high, then drops req. A req still high at the following
// arbitration edge counts as a new request. Dropping req before grant
// withdraws it without any gnt or done.
module alu_arbiter #(
  parameter int WIDTH      = 8,
  parameter int CTRL_W     = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [WIDTH-1:0]  a0,
  input  logic [WIDTH-1:0]  b0,
  input  logic [WIDTH-1:0]  a1,
  input  logic [WIDTH-1:0]  b1,
  input  logic [CTRL_W-1:0] ctrl0,
  input  logic [CTRL_W-1:0] ctrl1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [WIDTH-1:0]  res0,
  output logic [WIDTH-1:0]  res1,
  output logic              flag0,
  output logic              flag1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_c,
  input  logic              alu_f
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic               illegal_q, illegal_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0]   res0_q, res0_d, res1_q, res1_d;
  logic               flag0_q, flag0_d, flag1_q, flag1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;

  logic               win;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic               sel_illegal;

  // Winner selection and next-state / next-output computation
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    illegal_d  = illegal_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = 1'b0;
    res0_d     = res0_q;
    res1_d     = res1_q;
    flag0_d    = flag0_q;
    flag1_d    = flag1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;

    // Under contention the port that did not win last time goes next,
    // unless port 0 is given fixed priority.
    if (req0 && req1) win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    else              win = req1;
    sel_ctrl    = win ? ctrl1 : ctrl0;
    sel_illegal = (sel_ctrl == CTRL_W'(5)) || (sel_ctrl == CTRL_W'(7));

    case (state_q)
      IDLE, DONE: begin
        if (req0 || req1) begin
          alu_a_d    = win ? a1 : a0;
          alu_b_d    = win ? b1 : b0;
          // Illegal codes still run through the ALU as a harmless add;
          // the captured result is discarded at the EXEC edge.
          alu_ctrl_d = sel_illegal ? '0 : sel_ctrl;
          illegal_d  = sel_illegal;
          owner_d    = win;
          last_d     = win;
          gnt0_d     = ~win;
          gnt1_d     = win;
          busy_d     = 1'b1;
          state_d    = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (owner_q) begin
          res1_d  = illegal_q ? '0 : alu_c;
          flag1_d = illegal_q ? 1'b0 : alu_f;
          err1_d  = illegal_q;
          done1_d = 1'b1;
        end else begin
          res0_d  = illegal_q ? '0 : alu_c;
          flag0_d = illegal_q ? 1'b0 : alu_f;
          err0_d  = illegal_q;
          done0_d = 1'b1;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs; async reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      illegal_q  <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      res0_q     <= '0;
      res1_q     <= '0;
      flag0_q    <= 1'b0;
      flag1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      busy_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      illegal_q  <= illegal_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      flag0_q    <= flag0_d;
      flag1_q    <= flag1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      busy_q     <= busy_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res0     = res0_q;
  assign res1     = res1_q;
  assign flag0    = flag0_q;
  assign flag1    = flag1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign busy     = busy_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stub drives alu_c/alu_f, and a
// transaction-level model (last winner, per-port result registers) predicts
// every grant, done and returned result.
module tb_alu_arbiter;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int FP = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [CW-1:0] ctrl0, ctrl1;
  logic          gnt0, gnt1, done0, done1;
  logic [W-1:0]  res0, res1;
  logic          flag0, flag1, err0, err1, busy;
  logic [W-1:0]  alu_a, alu_b, alu_c;
  logic [CW-1:0] alu_ctrl;
  logic          alu_f;

  int total = 0;
  int bad   = 0;

  // model state
  logic [W-1:0] m_res[2];
  logic         m_flag[2];
  logic         m_err[2];
  int           m_last;

  alu_arbiter #(.WIDTH(W), .CTRL_W(CW), .FIXED_PRIO(FP)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ctrl0(ctrl0), .ctrl1(ctrl1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1), .flag0(flag0), .flag1(flag1),
    .err0(err0), .err1(err1), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_c(alu_c), .alu_f(alu_f)
  );

  always #5 clk = ~clk;

  // External ALU: {f, c}. Shifts are by one; f is carry/borrow/shifted-out
  // bit for arithmetic and shifts, zero-result for logic ops.
  function automatic logic [W:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [CW-1:0] c);
    logic [W-1:0] r;
    case (c)
      3'b000: return {1'b0, a} + {1'b0, b};
      3'b001: return {(a < b), a - b};
      3'b010: return {a[0], a >> 1};
      3'b011: begin r = ~(a | b); return {(r == 0), r}; end
      3'b100: begin r = ~(a & b); return {(r == 0), r}; end
      3'b110: return {a[W-1], a << 1};
      default: return '0;
    endcase
  endfunction

  always_comb {alu_f, alu_c} = alu_fn(alu_a, alu_b, alu_ctrl);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gnt and done are one-hot-or-zero every cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("done_excl", {31'd0, done0 & done1}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int p, logic r, logic [W-1:0] a, logic [W-1:0] b, logic [CW-1:0] c);
    if (p == 0) begin req0 = r; a0 = a; b0 = b; ctrl0 = c; end
    else        begin req1 = r; a1 = a; b1 = b; ctrl1 = c; end
  endtask

  function automatic logic is_illegal(logic [CW-1:0] c);
    return (c == 3'b101) || (c == 3'b111);
  endfunction

  task automatic model_exec(int p, logic [W-1:0] a, logic [W-1:0] b, logic [CW-1:0] c);
    logic [W:0] fc;
    if (is_illegal(c)) begin
      m_res[p] = '0; m_flag[p] = 1'b0; m_err[p] = 1'b1;
    end else begin
      fc = alu_fn(a, b, c);
      m_res[p] = fc[W-1:0]; m_flag[p] = fc[W]; m_err[p] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_res[i] = '0; m_flag[i] = 1'b0; m_err[i] = 1'b0;
    end
    m_last = 1;
  endtask

  task automatic check_ports(string tag);
    chk({tag, "_res0"},  {24'd0, res0},  {24'd0, m_res[0]});
    chk({tag, "_res1"},  {24'd0, res1},  {24'd0, m_res[1]});
    chk({tag, "_flag0"}, {31'd0, flag0}, {31'd0, m_flag[0]});
    chk({tag, "_flag1"}, {31'd0, flag1}, {31'd0, m_flag[1]});
    chk({tag, "_err0"},  {31'd0, err0},  {31'd0, m_err[0]});
    chk({tag, "_err1"},  {31'd0, err1},  {31'd0, m_err[1]});
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_outs"}, {gnt0, gnt1, done0, done1, flag0, flag1, err0, err1, busy}, 32'd0);
    chk({tag, "_res"},  {res0, res1}, 32'd0);
    chk({tag, "_alu"},  {alu_a, alu_b, 5'd0, alu_ctrl}, 32'd0);
  endtask

  // Expect a grant to port w for op (a,b,c); call at #1 after the accepting edge.
  task automatic expect_grant(string tag, int w, logic [W-1:0] a, logic [W-1:0] b, logic [CW-1:0] c);
    chk({tag, "_gnt"},  {gnt1, gnt0}, (w == 0) ? 32'd1 : 32'd2);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ndone"}, {done1, done0}, 32'd0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, {16'd0, a, b});
    chk({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, is_illegal(c) ? 32'd0 : {29'd0, c});
    m_last = w;
    model_exec(w, a, b, c);
  endtask

  task automatic expect_done(string tag, int w);
    chk({tag, "_done"}, {done1, done0}, (w == 0) ? 32'd1 : 32'd2);
    chk({tag, "_ngnt"}, {gnt1, gnt0}, 32'd0);
    chk({tag, "_nbusy"}, {31'd0, busy}, 32'd0);
    check_ports(tag);
  endtask

  // One op on a single port; called at #1 after an edge with state IDLE or DONE.
  task automatic single_op(string tag, int p, logic [W-1:0] a, logic [W-1:0] b, logic [CW-1:0] c);
    drive(p, 1'b1, a, b, c);
    step();
    expect_grant(tag, p, a, b, c);
    step();
    expect_done(tag, p);
    drive(p, 1'b0, W'($urandom), W'($urandom), CW'($urandom));
  endtask

  // Both ports request together; winner per model, loser served back to back.
  task automatic both_ops(string tag, logic [W-1:0] a0v, logic [W-1:0] b0v, logic [CW-1:0] c0v,
                          logic [W-1:0] a1v, logic [W-1:0] b1v, logic [CW-1:0] c1v);
    logic [W-1:0]  av[2];
    logic [W-1:0]  bv[2];
    logic [CW-1:0] cv[2];
    int w, l;
    av[0] = a0v; bv[0] = b0v; cv[0] = c0v;
    av[1] = a1v; bv[1] = b1v; cv[1] = c1v;
    drive(0, 1'b1, a0v, b0v, c0v);
    drive(1, 1'b1, a1v, b1v, c1v);
    w = (FP != 0) ? 0 : 1 - m_last;
    l = 1 - w;
    step();
    expect_grant({tag, "_w"}, w, av[w], bv[w], cv[w]);
    step();
    expect_done({tag, "_w"}, w);
    drive(w, 1'b0, av[w], bv[w], cv[w]);
    step();
    expect_grant({tag, "_l"}, l, av[l], bv[l], cv[l]);
    step();
    expect_done({tag, "_l"}, l);
    drive(l, 1'b0, av[l], bv[l], cv[l]);
  endtask

  logic [W-1:0]  ra, rb, ra2, rb2;
  logic [CW-1:0] rc, rc2;
  logic [W-1:0]  held_a;

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; ctrl0 = 0; ctrl1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Contention from reset: port 0 nand first, then port 1 nor back to back
    both_ops("contend", 8'h0F, 8'h05, 3'b100, 8'h0F, 8'h05, 3'b011);
    chk("contend_res0_k", {24'd0, res0}, 32'h0FA);
    chk("contend_res1_k", {24'd0, res1}, 32'h0F0);

    // Single add on port 0, then a cycle with no request: alu_* hold
    step();
    single_op("add0", 0, 8'h0F, 8'h05, 3'b000);
    chk("add0_res_k", {24'd0, res0}, 32'h014);
    chk("add0_res1_k", {24'd0, res1}, 32'h0F0);
    held_a = alu_a;
    step();
    chk("idle_busy", {gnt1, gnt0, done1, done0, busy}, 32'd0);
    chk("idle_hold_a", {24'd0, alu_a}, {24'd0, held_a});

    // Port 1: sub, sll, srl
    single_op("sub1", 1, 8'h0F, 8'h05, 3'b001);
    chk("sub1_res_k", {24'd0, res1}, 32'h00A);
    single_op("sll1", 1, 8'h0F, 8'h05, 3'b110);
    chk("sll1_res_k", {24'd0, res1}, 32'h01E);
    single_op("srl1", 1, 8'h0F, 8'h05, 3'b010);
    chk("srl1_res_k", {24'd0, res1}, 32'h007);

    // Illegal op on port 0, then a legal op clears err0
    step();
    single_op("ill0", 0, 8'h33, 8'h44, 3'b101);
    chk("ill0_err_k", {31'd0, err0}, 32'd1);
    chk("ill0_res_k", {24'd0, res0}, 32'd0);
    single_op("ill1_port1", 1, 8'h12, 8'h34, 3'b000);
    chk("ill0_err_kept", {31'd0, err0}, 32'd1);
    single_op("clr0", 0, 8'h01, 8'h02, 3'b000);
    chk("clr0_err_k", {31'd0, err0}, 32'd0);

    // Operand changes after grant are ignored
    step();
    drive(0, 1'b1, 8'h20, 8'h03, 3'b001);
    step();
    expect_grant("late", 0, 8'h20, 8'h03, 3'b001);
    a0 = 8'hFF; b0 = 8'hFF; ctrl0 = 3'b110;
    step();
    expect_done("late", 0);
    chk("late_res_k", {24'd0, res0}, 32'h01D);
    drive(0, 1'b0, 0, 0, 0);

    // Withdrawn request: no grant, no done
    step();
    req1 = 1'b1;
    #3;
    req1 = 1'b0;
    step();
    chk("withdraw_gnt", {gnt1, gnt0, busy}, 32'd0);
    step();
    chk("withdraw_done", {done1, done0}, 32'd0);

    // Fairness: both requests continuously asserted for 8 ops
    ra = W'($urandom); rb = W'($urandom); rc = CW'($urandom_range(0, 7));
    ra2 = W'($urandom); rb2 = W'($urandom); rc2 = CW'($urandom_range(0, 7));
    drive(0, 1'b1, ra, rb, rc);
    drive(1, 1'b1, ra2, rb2, rc2);
    for (int i = 0; i < 8; i++) begin
      int w;
      w = (FP != 0) ? 0 : 1 - m_last;
      step();
      if (w == 0) expect_grant($sformatf("fair%0d", i), 0, a0, b0, ctrl0);
      else        expect_grant($sformatf("fair%0d", i), 1, a1, b1, ctrl1);
      step();
      expect_done($sformatf("fair%0d", i), w);
      drive(w, 1'b1, W'($urandom), W'($urandom), CW'($urandom_range(0, 7)));
    end
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    step();

    // Random single-port and contended ops
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = CW'($urandom_range(0, 7));
      ra2 = W'($urandom); rb2 = W'($urandom); rc2 = CW'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: single_op($sformatf("rnd%0d", i), 0, ra, rb, rc);
        1: single_op($sformatf("rnd%0d", i), 1, ra2, rb2, rc2);
        default: both_ops($sformatf("rnd%0d", i), ra, rb, rc, ra2, rb2, rc2);
      endcase
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset during EXEC: outputs clear immediately, no done afterwards
    step();
    drive(0, 1'b1, 8'h40, 8'h02, 3'b000);
    step();
    chk("rstmid_gnt", {gnt1, gnt0}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all_zero("rstmid");
    drive(0, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rstmid_nodone", {done1, done0, gnt1, gnt0}, 32'd0);
    single_op("post_rst", 1, 8'h01, 8'h01, 3'b000);
    chk("post_rst_res_k", {24'd0, res1}, 32'h002);
    // last winner was port 1, so port 0 takes the next contention
    both_ops("post_rst_c", 8'h03, 8'h04, 3'b000, 8'h05, 8'h06, 3'b000);
    chk("post_rst_res0_k", {24'd0, res0}, 32'h007);
    chk("post_rst_res1_k", {24'd0, res1}, 32'h00B);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
